// File: rtl/csr_irq_unit_if.sv
// -----------------------------------------------------------------------------
// csr_irq_unit_if
// MW-stage bus between the pipeline and the machine-mode CSR / interrupt unit.
//
// Signals:
//   csr_reg_rd, csr_reg_wr  CSR read / write strobes of the MW instruction
//   csr_op                  01=RW, 10=RS, 11=RC, 00=no write
//   csr_addr                CSR address (inst[31:20])
//   csr_wdata               rs1 value or zero-extended zimm
//   csr_rdata               combinational read data (old value)
//   pc_mw                   PC of the MW-stage instruction
//   is_mret                 MW instruction is mret
//   stall                   MW instruction does not commit this cycle
//   epc_taken               redirect the PC this cycle
//   epc_target              redirect address
//   csr_flush               flush the younger stage (mirrors epc_taken)
//   illegal_csr             access to an unimplemented CSR address
//
// Modports: master = pipeline side, slave = csr_irq_unit.
// -----------------------------------------------------------------------------
interface csr_irq_unit_if #(
    parameter int unsigned XLEN = 32
) ();
    logic            csr_reg_rd;
    logic            csr_reg_wr;
    logic [1:0]      csr_op;
    logic [11:0]     csr_addr;
    logic [XLEN-1:0] csr_wdata;
    logic [XLEN-1:0] csr_rdata;
    logic [XLEN-1:0] pc_mw;
    logic            is_mret;
    logic            stall;
    logic            epc_taken;
    logic [XLEN-1:0] epc_target;
    logic            csr_flush;
    logic            illegal_csr;

    modport master (
        output csr_reg_rd, csr_reg_wr, csr_op, csr_addr, csr_wdata,
               pc_mw, is_mret, stall,
        input  csr_rdata, epc_taken, epc_target, csr_flush, illegal_csr
    );

    modport slave (
        input  csr_reg_rd, csr_reg_wr, csr_op, csr_addr, csr_wdata,
               pc_mw, is_mret, stall,
        output csr_rdata, epc_taken, epc_target, csr_flush, illegal_csr
    );
endinterface

// File: rtl/csr_irq_unit.sv
// -----------------------------------------------------------------------------
// csr_irq_unit
// Machine-mode CSR file and interrupt controller for the MW stage of the
// 3-stage RV32 core. Provides mstatus/mie/mtvec/mscratch/mepc/mcause/mip,
// a 64-bit mcycle counter, NUM_IRQ fixed-priority external interrupts and
// direct or vectored trap entry. The registered redirect (epc_taken /
// epc_target / csr_flush) drives the PC mux and the first pipeline flush.
//
// Parameters:
//   XLEN       datapath width (only 32 supported)
//   NUM_IRQ    external interrupt lines, 1..16
//   MTVEC_RST  reset value of mtvec
//
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous, active-low reset
//   irq   level-sensitive external interrupts, asynchronous to clk
//   bus   csr_irq_unit_if.slave (CSR access, mret, stall, redirect)
//
// Optional feature macro: CSR_TIMER_EN
//   Defined   : 64-bit mtimecmp at 0x7C0/0x7C1, timer interrupt (cause 7)
//               through mip/mie bit 7.
//   Undefined : mip/mie bit 7 read 0, 0x7C0/0x7C1 raise illegal_csr.
// -----------------------------------------------------------------------------
module csr_irq_unit #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned NUM_IRQ   = 4,
    parameter logic [31:0] MTVEC_RST = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq,
    csr_irq_unit_if.slave      bus
);

    localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] ADDR_MIE      = 12'h304;
    localparam logic [11:0] ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] ADDR_MEPC     = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
    localparam logic [11:0] ADDR_MIP      = 12'h344;
    localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
    localparam logic [11:0] ADDR_MCYCLEH  = 12'hB80;
`ifdef CSR_TIMER_EN
    localparam logic [11:0] ADDR_MTIMECMP  = 12'h7C0;
    localparam logic [11:0] ADDR_MTIMECMPH = 12'h7C1;
`endif

    localparam logic [1:0] OP_RW = 2'b01;
    localparam logic [1:0] OP_RS = 2'b10;
    localparam logic [1:0] OP_RC = 2'b11;

    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    // ---------------------------------------------------------------- state
    logic               mstatus_mie;
    logic               mstatus_mpie;
    logic [NUM_IRQ-1:0] mie_meie;
    logic               mie_mtie;
    logic [XLEN-1:0]    mtvec;
    logic [XLEN-1:0]    mscratch;
    logic [XLEN-1:0]    mepc;
    logic [XLEN-1:0]    mcause;
    logic [63:0]        mcycle;
    logic [NUM_IRQ-1:0] irq_meta;
    logic [NUM_IRQ-1:0] irq_sync;
    logic               mip_mtip;
`ifdef CSR_TIMER_EN
    logic [63:0]        mtimecmp;
`endif
    logic               epc_taken_q;
    logic [XLEN-1:0]    epc_target_q;

    // ------------------------------------------------------ composed views
    logic [XLEN-1:0] mstatus_val;
    logic [XLEN-1:0] mie_val;
    logic [XLEN-1:0] mip_val;

    // NOTE: every signal written in an always_comb gets a default first, so
    // no path through the block can leave it unassigned and infer a latch.
    always_comb begin
        mstatus_val    = '0;
        mstatus_val[3] = mstatus_mie;
        mstatus_val[7] = mstatus_mpie;

        mie_val              = '0;
        mie_val[7]           = mie_mtie;
        mie_val[16+:NUM_IRQ] = mie_meie;

        mip_val              = '0;
        mip_val[7]           = mip_mtip;
        mip_val[16+:NUM_IRQ] = irq_sync;
    end

    // ------------------------------------------------------- address decode
    logic [XLEN-1:0] csr_old;
    logic            csr_hit;

    always_comb begin
        csr_old = '0;
        csr_hit = 1'b1;
        case (bus.csr_addr)
            ADDR_MSTATUS:   csr_old = mstatus_val;
            ADDR_MIE:       csr_old = mie_val;
            ADDR_MTVEC:     csr_old = mtvec;
            ADDR_MSCRATCH:  csr_old = mscratch;
            ADDR_MEPC:      csr_old = mepc;
            ADDR_MCAUSE:    csr_old = mcause;
            ADDR_MIP:       csr_old = mip_val;
            ADDR_MCYCLE:    csr_old = mcycle[31:0];
            ADDR_MCYCLEH:   csr_old = mcycle[63:32];
`ifdef CSR_TIMER_EN
            ADDR_MTIMECMP:  csr_old = mtimecmp[31:0];
            ADDR_MTIMECMPH: csr_old = mtimecmp[63:32];
`endif
            default:        csr_hit = 1'b0;
        endcase
    end

    assign bus.csr_rdata   = (bus.csr_reg_rd && csr_hit) ? csr_old : '0;
    assign bus.illegal_csr = (bus.csr_reg_rd || bus.csr_reg_wr) && !csr_hit;

    // ------------------------------------------------ read-modify-write value
    logic [XLEN-1:0] csr_new;

    always_comb begin
        case (bus.csr_op)
            OP_RW:   csr_new = bus.csr_wdata;
            OP_RS:   csr_new = csr_old | bus.csr_wdata;
            OP_RC:   csr_new = csr_old & ~bus.csr_wdata;
            default: csr_new = csr_old;
        endcase
    end

    // ------------------------------------------------ interrupt arbitration
    logic [NUM_IRQ-1:0] ext_pending;
    logic               timer_pending;
    logic               irq_pending;
    logic [4:0]         trap_code;
    logic               trap_fire;
    logic               mret_fire;
    logic [XLEN-1:0]    trap_target;

    assign ext_pending   = irq_sync & mie_meie;
    assign timer_pending = mip_mtip & mie_mtie;
    assign irq_pending   = (|ext_pending) | timer_pending;

    // Scan from the lowest-priority line upward so irq[0] wins; the timer
    // (cause 7) only remains when no external line is pending.
    always_comb begin
        trap_code = 5'd7;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (ext_pending[i]) begin
                trap_code = 5'(16 + i);
            end
        end
    end

    // mret in MW blocks the interrupt for this cycle; with MIE restored it is
    // taken on the first cycle after the mret redirect.
    assign trap_fire = mstatus_mie && irq_pending && !bus.stall &&
                       !bus.is_mret && !epc_taken_q;
    assign mret_fire = bus.is_mret && !bus.stall && !epc_taken_q;

    always_comb begin
        trap_target = mtvec & ALIGN_MASK;
        if (mtvec[1:0] == 2'b01) begin
            trap_target = (mtvec & ALIGN_MASK) + XLEN'({trap_code, 2'b00});
        end
    end

    // ---------------------------------------------------------- CSR writes
    logic csr_wr_en;
    logic wr_mstatus;
    logic wr_mie;
    logic wr_mtvec;
    logic wr_mscratch;
    logic wr_mepc;
    logic wr_mcause;
    logic wr_mcycle;
    logic wr_mcycleh;

    // A trap or an in-flight redirect squashes the MW instruction's write.
    assign csr_wr_en   = bus.csr_reg_wr && (bus.csr_op != 2'b00) && !bus.stall &&
                         !trap_fire && !epc_taken_q;
    assign wr_mstatus  = csr_wr_en && (bus.csr_addr == ADDR_MSTATUS);
    assign wr_mie      = csr_wr_en && (bus.csr_addr == ADDR_MIE);
    assign wr_mtvec    = csr_wr_en && (bus.csr_addr == ADDR_MTVEC);
    assign wr_mscratch = csr_wr_en && (bus.csr_addr == ADDR_MSCRATCH);
    assign wr_mepc     = csr_wr_en && (bus.csr_addr == ADDR_MEPC);
    assign wr_mcause   = csr_wr_en && (bus.csr_addr == ADDR_MCAUSE);
    assign wr_mcycle   = csr_wr_en && (bus.csr_addr == ADDR_MCYCLE);
    assign wr_mcycleh  = csr_wr_en && (bus.csr_addr == ADDR_MCYCLEH);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs at the same edge regardless of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
        end else if (trap_fire) begin
            mstatus_mpie <= mstatus_mie;
            mstatus_mie  <= 1'b0;
        end else if (mret_fire) begin
            mstatus_mie  <= mstatus_mpie;
            mstatus_mpie <= 1'b1;
        end else if (wr_mstatus) begin
            mstatus_mie  <= csr_new[3];
            mstatus_mpie <= csr_new[7];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mie_meie <= '0;
        end else if (wr_mie) begin
            mie_meie <= csr_new[16+:NUM_IRQ];
        end
    end

    // mtvec mode is WARL: reserved modes 1x collapse to direct.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mtvec <= XLEN'(MTVEC_RST);
        end else if (wr_mtvec) begin
            mtvec <= csr_new[1] ? (csr_new & ALIGN_MASK) : csr_new;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mscratch <= '0;
            mepc     <= '0;
            mcause   <= '0;
        end else begin
            if (wr_mscratch) begin
                mscratch <= csr_new;
            end
            if (trap_fire) begin
                mepc   <= bus.pc_mw & ALIGN_MASK;
                mcause <= {1'b1, (XLEN-1)'(trap_code)};
            end else begin
                if (wr_mepc) begin
                    mepc <= csr_new & ALIGN_MASK;
                end
                if (wr_mcause) begin
                    mcause <= csr_new;
                end
            end
        end
    end

    // Free-running counter; a write to either half replaces only that half
    // and skips the increment for that cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcycle <= '0;
        end else if (wr_mcycle) begin
            mcycle[31:0] <= csr_new;
        end else if (wr_mcycleh) begin
            mcycle[63:32] <= csr_new;
        end else begin
            mcycle <= mcycle + 64'd1;
        end
    end

    // Two-flop synchroniser for the asynchronous interrupt lines.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_meta <= '0;
            irq_sync <= '0;
        end else begin
            irq_meta <= irq;
            irq_sync <= irq_meta;
        end
    end

`ifdef CSR_TIMER_EN
    logic wr_mtimecmp;
    logic wr_mtimecmph;

    assign wr_mtimecmp  = csr_wr_en && (bus.csr_addr == ADDR_MTIMECMP);
    assign wr_mtimecmph = csr_wr_en && (bus.csr_addr == ADDR_MTIMECMPH);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mtimecmp <= '1;
            mip_mtip <= 1'b0;
            mie_mtie <= 1'b0;
        end else begin
            if (wr_mtimecmp) begin
                mtimecmp[31:0] <= csr_new;
            end
            if (wr_mtimecmph) begin
                mtimecmp[63:32] <= csr_new;
            end
            if (wr_mie) begin
                mie_mtie <= csr_new[7];
            end
            mip_mtip <= (mcycle >= mtimecmp);
        end
    end
`else
    assign mip_mtip = 1'b0;
    assign mie_mtie = 1'b0;
`endif

    // ------------------------------------------------------------ redirect
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            epc_taken_q  <= 1'b0;
            epc_target_q <= '0;
        end else begin
            epc_taken_q <= trap_fire || mret_fire;
            if (trap_fire) begin
                epc_target_q <= trap_target;
            end else if (mret_fire) begin
                epc_target_q <= mepc;
            end
        end
    end

    assign bus.epc_taken  = epc_taken_q;
    assign bus.epc_target = epc_target_q;
    assign bus.csr_flush  = epc_taken_q;

endmodule

// File: tb/tb_csr_irq_unit.sv
// -----------------------------------------------------------------------------
// tb_csr_irq_unit
// Directed testbench for csr_irq_unit (NUM_IRQ=4, MTVEC_RST=0). Inputs are
// driven 1 ns after the rising edge; outputs are sampled before the next edge.
// Covers the CSR_TIMER_EN build and the default build through the same macro.
// -----------------------------------------------------------------------------
module tb_csr_irq_unit;

    localparam logic [1:0] OP_RW = 2'b01;
    localparam logic [1:0] OP_RS = 2'b10;
    localparam logic [1:0] OP_RC = 2'b11;

    logic       clk;
    logic       rst;
    logic [3:0] irq;

    int checks = 0;
    int errors = 0;

    csr_irq_unit_if #(.XLEN(32)) bus ();

    csr_irq_unit #(
        .XLEN      (32),
        .NUM_IRQ   (4),
        .MTVEC_RST (32'h0000_0000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .irq (irq),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its end, time=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------ helpers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        bus.csr_reg_rd = 1'b0;
        bus.csr_reg_wr = 1'b0;
        bus.csr_op     = 2'b00;
        bus.csr_addr   = 12'h000;
        bus.csr_wdata  = 32'h0;
    endtask

    // One CSR instruction in MW for one cycle; returns the old value read.
    task automatic csr_instr(input logic [1:0] op, input logic [11:0] addr,
                             input logic [31:0] wdata, output logic [31:0] old);
        bus.csr_reg_rd = 1'b1;
        bus.csr_reg_wr = 1'b1;
        bus.csr_op     = op;
        bus.csr_addr   = addr;
        bus.csr_wdata  = wdata;
        #1;
        old = bus.csr_rdata;
        tick();
        bus_idle();
    endtask

    task automatic csr_read(input logic [11:0] addr, output logic [31:0] val);
        bus.csr_reg_rd = 1'b1;
        bus.csr_addr   = addr;
        #1;
        val = bus.csr_rdata;
        bus_idle();
    endtask

    // -------------------------------------------------------------- tests
    task automatic test_reset();
        logic [31:0] v;
        rst = 1'b0;
        irq = 4'h0;
        bus_idle();
        bus.pc_mw   = 32'h0;
        bus.is_mret = 1'b0;
        bus.stall   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.epc_taken !== 1'b0) begin
            errors++;
            $display("FAIL reset_epc_taken: got %0h expected 0", bus.epc_taken);
        end
        checks++;
        if (bus.epc_target !== 32'h0) begin
            errors++;
            $display("FAIL reset_epc_target: got %08h expected 00000000", bus.epc_target);
        end
        checks++;
        if (bus.csr_flush !== 1'b0) begin
            errors++;
            $display("FAIL reset_csr_flush: got %0h expected 0", bus.csr_flush);
        end
        rst = 1'b1;
        tick();
        csr_read(12'h300, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL reset_mstatus: got %08h expected 00000000", v);
        end
        csr_read(12'h305, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL reset_mtvec: got %08h expected 00000000", v);
        end
        csr_read(12'hB80, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL reset_mcycleh: got %08h expected 00000000", v);
        end
    endtask

    task automatic test_csr_access();
        logic [31:0] v;
        csr_instr(OP_RW, 12'h340, 32'hDEAD_BEEF, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL csrrw_old: got %08h expected 00000000", v);
        end
        csr_instr(OP_RS, 12'h340, 32'h0000_0001, v);
        checks++;
        if (v !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL csrrs_old: got %08h expected deadbeef", v);
        end
        csr_read(12'h340, v);
        checks++;
        if (v !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL mscratch_value: got %08h expected deadbeef", v);
        end
        // Set MIE and some unimplemented bits; only bit 3 survives.
        csr_instr(OP_RS, 12'h300, 32'h0000_0F0F, v);
        csr_read(12'h300, v);
        checks++;
        if (v !== 32'h0000_0008) begin
            errors++;
            $display("FAIL mstatus_set: got %08h expected 00000008", v);
        end
        // Stalled CSRRC must not commit.
        bus.stall = 1'b1;
        csr_instr(OP_RC, 12'h300, 32'h0000_0008, v);
        bus.stall = 1'b0;
        csr_read(12'h300, v);
        checks++;
        if (v !== 32'h0000_0008) begin
            errors++;
            $display("FAIL mstatus_stall: got %08h expected 00000008", v);
        end
        // mepc low bits forced to zero.
        csr_instr(OP_RW, 12'h341, 32'h0000_1237, v);
        csr_read(12'h341, v);
        checks++;
        if (v !== 32'h0000_1234) begin
            errors++;
            $display("FAIL mepc_align: got %08h expected 00001234", v);
        end
        // mip is read-only and not illegal.
        bus.csr_reg_wr = 1'b1;
        bus.csr_op     = OP_RW;
        bus.csr_addr   = 12'h344;
        bus.csr_wdata  = 32'hFFFF_FFFF;
        #1;
        checks++;
        if (bus.illegal_csr !== 1'b0) begin
            errors++;
            $display("FAIL mip_write_illegal: got %0h expected 0", bus.illegal_csr);
        end
        tick();
        bus_idle();
        csr_read(12'h344, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL mip_readonly: got %08h expected 00000000", v);
        end
    endtask

    task automatic test_direct_trap();
        logic [31:0] v;
        csr_instr(OP_RW, 12'h305, 32'h0000_0100, v);
        csr_instr(OP_RS, 12'h304, 32'h0001_0000, v);
        bus.pc_mw = 32'h0000_0040;
        irq[0] = 1'b1;
        tick();
        checks++;
        if (bus.epc_taken !== 1'b0) begin
            errors++;
            $display("FAIL direct_sync1: got %0h expected 0", bus.epc_taken);
        end
        tick();
        checks++;
        if (bus.epc_taken !== 1'b0) begin
            errors++;
            $display("FAIL direct_sync2: got %0h expected 0", bus.epc_taken);
        end
        tick();
        checks++;
        if (bus.epc_taken !== 1'b1 || bus.csr_flush !== 1'b1) begin
            errors++;
            $display("FAIL direct_taken: got taken=%0h flush=%0h expected 1/1",
                     bus.epc_taken, bus.csr_flush);
        end
        checks++;
        if (bus.epc_target !== 32'h0000_0100) begin
            errors++;
            $display("FAIL direct_target: got %08h expected 00000100", bus.epc_target);
        end
        csr_read(12'h341, v);
        checks++;
        if (v !== 32'h0000_0040) begin
            errors++;
            $display("FAIL direct_mepc: got %08h expected 00000040", v);
        end
        csr_read(12'h342, v);
        checks++;
        if (v !== 32'h8000_0010) begin
            errors++;
            $display("FAIL direct_mcause: got %08h expected 80000010", v);
        end
        csr_read(12'h300, v);
        checks++;
        if (v !== 32'h0000_0080) begin
            errors++;
            $display("FAIL direct_mstatus: got %08h expected 00000080", v);
        end
        irq[0] = 1'b0;
        tick();
        checks++;
        if (bus.epc_taken !== 1'b0) begin
            errors++;
            $display("FAIL direct_one_cycle: got %0h expected 0", bus.epc_taken);
        end
        tick();
        tick();
    endtask

    task automatic test_vectored_priority();
        logic [31:0] v;
        csr_instr(OP_RW, 12'h305, 32'h0000_0201, v);
        csr_read(12'h305, v);
        checks++;
        if (v !== 32'h0000_0201) begin
            errors++;
            $display("FAIL mtvec_vectored: got %08h expected 00000201", v);
        end
        csr_instr(OP_RW, 12'h304, 32'h0006_0000, v);
        irq = 4'b0110;
        tick();
        tick();
        csr_read(12'h344, v);
        checks++;
        if (v !== 32'h0006_0000) begin
            errors++;
            $display("FAIL vec_mip: got %08h expected 00060000", v);
        end
        // Enable MIE; the trap fires in the following cycle.
        csr_instr(OP_RS, 12'h300, 32'h0000_0008, v);
        tick();
        checks++;
        if (bus.epc_taken !== 1'b1 || bus.epc_target !== 32'h0000_0244) begin
            errors++;
            $display("FAIL vec_target: got taken=%0h target=%08h expected 1/00000244",
                     bus.epc_taken, bus.epc_target);
        end
        csr_read(12'h342, v);
        checks++;
        if (v !== 32'h8000_0011) begin
            errors++;
            $display("FAIL vec_mcause: got %08h expected 80000011", v);
        end
        irq = 4'b0000;
        tick();
        csr_instr(OP_RW, 12'h305, 32'h0000_0203, v);
        csr_read(12'h305, v);
        checks++;
        if (v !== 32'h0000_0200) begin
            errors++;
            $display("FAIL mtvec_warl: got %08h expected 00000200", v);
        end
        tick();
        tick();
    endtask

    task automatic test_mret_collision();
        logic [31:0] v;
        // State here: MIE=0, MPIE=1, mtvec=0x200 (direct).
        csr_instr(OP_RW, 12'h341, 32'h0000_0080, v);
        csr_instr(OP_RW, 12'h304, 32'h0001_0000, v);
        irq[0] = 1'b1;
        tick();
        tick();
        // MIE=1 lands while the interrupt is pending and mret sits in MW.
        csr_instr(OP_RS, 12'h300, 32'h0000_0008, v);
        bus.is_mret = 1'b1;
        tick();
        bus.is_mret = 1'b0;
        checks++;
        if (bus.epc_taken !== 1'b1 || bus.epc_target !== 32'h0000_0080) begin
            errors++;
            $display("FAIL mret_redirect: got taken=%0h target=%08h expected 1/00000080",
                     bus.epc_taken, bus.epc_target);
        end
        csr_read(12'h300, v);
        checks++;
        if (v !== 32'h0000_0088) begin
            errors++;
            $display("FAIL mret_mstatus: got %08h expected 00000088", v);
        end
        tick();
        checks++;
        if (bus.epc_taken !== 1'b0) begin
            errors++;
            $display("FAIL mret_gap: got %0h expected 0", bus.epc_taken);
        end
        tick();
        checks++;
        if (bus.epc_taken !== 1'b1 || bus.epc_target !== 32'h0000_0200) begin
            errors++;
            $display("FAIL back_to_back_irq: got taken=%0h target=%08h expected 1/00000200",
                     bus.epc_taken, bus.epc_target);
        end
        csr_read(12'h342, v);
        checks++;
        if (v !== 32'h8000_0010) begin
            errors++;
            $display("FAIL back_to_back_mcause: got %08h expected 80000010", v);
        end
        // Reset while the redirect is active aborts it.
        rst = 1'b0;
        #1;
        checks++;
        if (bus.epc_taken !== 1'b0 || bus.epc_target !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_trap: got taken=%0h target=%08h expected 0/00000000",
                     bus.epc_taken, bus.epc_target);
        end
        irq = 4'b0000;
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_mcycle();
        logic [31:0] v;
        csr_instr(OP_RW, 12'hB00, 32'hFFFF_FFFF, v);
        csr_instr(OP_RW, 12'hB80, 32'hFFFF_FFFF, v);
        csr_read(12'hB00, v);
        checks++;
        if (v !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL mcycle_write_hold: got %08h expected ffffffff", v);
        end
        tick();
        tick();
        csr_read(12'hB00, v);
        checks++;
        if (v !== 32'h0000_0001) begin
            errors++;
            $display("FAIL mcycle_wrap_lo: got %08h expected 00000001", v);
        end
        csr_read(12'hB80, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL mcycle_wrap_hi: got %08h expected 00000000", v);
        end
    endtask

    task automatic test_illegal();
        bus.csr_reg_rd = 1'b1;
        bus.csr_addr   = 12'h7FF;
        #1;
        checks++;
        if (bus.illegal_csr !== 1'b1 || bus.csr_rdata !== 32'h0) begin
            errors++;
            $display("FAIL illegal_read: got illegal=%0h rdata=%08h expected 1/00000000",
                     bus.illegal_csr, bus.csr_rdata);
        end
        bus.csr_reg_rd = 1'b0;
        bus.csr_reg_wr = 1'b1;
        bus.csr_op     = OP_RW;
        #1;
        checks++;
        if (bus.illegal_csr !== 1'b1) begin
            errors++;
            $display("FAIL illegal_write: got %0h expected 1", bus.illegal_csr);
        end
        bus_idle();
        bus.csr_reg_rd = 1'b1;
        bus.csr_addr   = 12'h340;
        #1;
        checks++;
        if (bus.illegal_csr !== 1'b0) begin
            errors++;
            $display("FAIL legal_no_flag: got %0h expected 0", bus.illegal_csr);
        end
        bus_idle();
        tick();
    endtask

    task automatic test_timer();
        logic [31:0] v;
        logic        seen;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
`ifdef CSR_TIMER_EN
        csr_read(12'h7C1, v);
        checks++;
        if (v !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL mtimecmp_reset: got %08h expected ffffffff", v);
        end
        csr_instr(OP_RW, 12'h7C0, 32'd20, v);
        csr_instr(OP_RW, 12'h7C1, 32'd0, v);
        csr_instr(OP_RS, 12'h304, 32'h0000_0080, v);
        csr_instr(OP_RS, 12'h300, 32'h0000_0008, v);
        seen = 1'b0;
        for (int n = 0; n < 100 && !seen; n++) begin
            tick();
            seen = bus.epc_taken;
        end
        checks++;
        if (seen !== 1'b1) begin
            errors++;
            $display("FAIL timer_trap: got no redirect within 100 cycles expected one");
        end
        csr_read(12'h342, v);
        checks++;
        if (v !== 32'h8000_0007) begin
            errors++;
            $display("FAIL timer_mcause: got %08h expected 80000007", v);
        end
`else
        csr_instr(OP_RS, 12'h304, 32'h0000_0080, v);
        csr_read(12'h304, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL mtie_hardwired: got %08h expected 00000000", v);
        end
        csr_instr(OP_RS, 12'h300, 32'h0000_0008, v);
        seen = 1'b0;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (bus.epc_taken === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL timer_absent: got a redirect expected none");
        end
        bus.csr_reg_rd = 1'b1;
        bus.csr_addr   = 12'h7C0;
        #1;
        checks++;
        if (bus.illegal_csr !== 1'b1 || bus.csr_rdata !== 32'h0) begin
            errors++;
            $display("FAIL mtimecmp_illegal: got illegal=%0h rdata=%08h expected 1/00000000",
                     bus.illegal_csr, bus.csr_rdata);
        end
        bus_idle();
`endif
    endtask

    initial begin
        test_reset();
        test_csr_access();
        test_direct_trap();
        test_vectored_priority();
        test_mret_collision();
        test_mcycle();
        test_illegal();
        test_timer();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/csr_irq_unit.md
Name: csr_irq_unit

Overview:
Machine-mode CSR file and interrupt controller for the 3-stage pipelined RV32 core, sitting at the memory/writeback (MW) stage beside the hazard logic. It generalises the existing fixed CSR/mret path:
- NUM_IRQ parametrised external interrupt lines with fixed priority
- direct or vectored trap entry
- a 64-bit cycle counter

Its redirect and flush outputs drive the PC mux and the first pipeline register's flush.

Parameters:
XLEN, 32, datapath width (only 32 supported)
NUM_IRQ, 4, external interrupt lines, 1..16
MTVEC_RST, 32'h0000_0000, reset value of mtvec

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-low
csr_reg_rd  in  1  CSR read strobe for the MW-stage instruction
csr_reg_wr  in  1  CSR write strobe for the MW-stage instruction
csr_op  in  2  01=RW, 10=RS (set), 11=RC (clear); 00 = no write
csr_addr  in  12  CSR address (inst[31:20])
csr_wdata  in  XLEN  rs1 value or zero-extended zimm
csr_rdata  out  XLEN  combinational read data (old value)
pc_mw  in  XLEN  PC of the MW-stage instruction
is_mret  in  1  MW-stage instruction is mret
stall  in  1  Stall_MW; MW instruction does not commit
irq  in  NUM_IRQ  level-sensitive external interrupts, asynchronous to clk
epc_taken  out  1  redirect PC this cycle
epc_target  out  XLEN  redirect address
csr_flush  out  1  flush the younger stage; equals epc_taken
illegal_csr  out  1  access to an unimplemented CSR address

Behaviour:
- Reset (rst=0, async):
  - mstatus=0, mie=0, mtvec=MTVEC_RST, mepc=0, mcause=0, mscratch=0, mcycle=0
  - irq synchronisers=0
  - epc_taken=0, epc_target=0, illegal_csr=0
  - Reset mid-trap aborts the redirect.
- Implemented CSRs:
  - mstatus 0x300: MIE bit3, MPIE bit7; all other bits read 0.
  - mie 0x304: MTIE bit7; MEIE_i at bit 16+i. Unused bits read 0.
  - mtvec 0x305: mode field [1:0] is WARL; a written value of 1x stores 00.
  - mscratch 0x340.
  - mepc 0x341: bits[1:0] forced to 0.
  - mcause 0x342.
  - mip 0x344: read-only; writes ignored, no illegal flag.
  - mcycle 0xB00, mcycleh 0xB80.
- Read: csr_rdata = current value when csr_reg_rd=1, else 0. Unimplemented address with rd or wr → csr_rdata=0, illegal_csr=1 (combinational).
- Write commits on the clock edge when csr_reg_wr & csr_op≠00 & !stall & !trap_fire & !epc_taken:
  - RW: new = wdata
  - RS: new = old | wdata
  - RC: new = old & ~wdata
- mcycle:
  - 64-bit, increments every cycle, including during stall; wraps 2^64-1 → 0.
  - A write to either half replaces that half and suppresses that cycle's increment.
- Interrupt inputs: each irq[i] passes through a 2-flop synchroniser into mip bit 16+i. Assert-to-mip latency is 2 cycles.
- Trap condition (trap_fire): mstatus.MIE & |(mip & mie) & !stall & !is_mret & !epc_taken.
- Priority: irq[0] highest … irq[NUM_IRQ-1], then timer (cause 7) lowest. Cause code = 16+i for external, 7 for timer.
- On trap_fire (clock edge):
  - mepc ← pc_mw; mcause ← {1'b1, code}
  - MPIE ← MIE; MIE ← 0
  - The MW instruction is not committed; its CSR write is suppressed.
- On is_mret & !stall & !epc_taken:
  - MIE ← MPIE; MPIE ← 1.
  - mret beats a simultaneous interrupt; the interrupt fires on the following eligible cycle.
- Redirect timing: epc_taken is registered. It is high for exactly 1 cycle, the cycle after trap_fire or mret commit.
  - After a trap, epc_target = mtvec base when mode=00, or base + 4×code when mode=01.
  - After mret, epc_target = mepc.
  - While epc_taken=1, no CSR write, trap or mret commits.
- Back-to-back: a trap is eligible again the cycle after epc_taken drops, provided MIE=1.

Optional Feature:
CSR_TIMER_EN
- Defined:
  - 64-bit mtimecmp at custom CSRs 0x7C0 (lo) / 0x7C1 (hi), reset value all-ones.
  - mip bit7 = (mcycle ≥ mtimecmp), registered one cycle.
  - mie bit7 is writable.
- Undefined:
  - mip bit7 and mie bit7 are hardwired to 0.
  - 0x7C0/0x7C1 are unimplemented and raise illegal_csr.

Test Plan:
- Reset + CSR access: rst low then high; CSRRW 0x340 wdata=0xDEADBEEF, then CSRRS 0x340 wdata=0x1 → second read returns 0xDEADBEEF, mscratch=0xDEADBEEF. CSRRC 0x300 while stall=1 → mstatus unchanged.
- Direct trap: mtvec=0x100, mie bit16=1, MIE=1, pc_mw=0x40, raise irq[0] → trap fires 2 cycles later; next cycle epc_taken=1, epc_target=0x100, mepc=0x40, mcause=0x8000_0010, MIE=0, MPIE=1.
- Vectored + priority: mtvec=0x201 (stored 0x201, base 0x200), irq[1] and irq[2] both enabled and asserted → cause 17, epc_target=0x244. A write of 0x203 to mtvec reads back 0x200.
- mret vs interrupt collision: is_mret=1 with mepc=0x80 and MPIE=1, irq pending same cycle → epc_target=0x80 first, MIE=1; interrupt redirect follows 2 cycles later.
- mcycle wrap/write: write mcycle=0xFFFF_FFFF, mcycleh=0xFFFF_FFFF → two cycles later reads 0x0000_0001 / 0x0. Access 0x7FF → illegal_csr=1, csr_rdata=0.
- CSR_TIMER_EN: mtimecmp=20 after reset, MTIE=1, MIE=1 → trap with mcause=0x8000_0007 once mcycle reaches 20. Build without the macro → no trap, 0x7C0 access flags illegal_csr.
